// File: rtl/div_seq_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master holds start, op, a and b; the divider samples them only while busy is low.
interface div_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] out;

  modport master (output start, op, a, b, input busy, done, out);
  modport slave  (input start, op, a, b, output busy, done, out);
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a start/busy/done handshake.
// Optional DIV_SEQ_EARLY_OUT_EN: divide-by-zero and signed overflow go straight to FIN.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_seq_if.slave   bus,
  output logic [1:0] o_dbg_state
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIN = 2'd2} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_a_orig;
  logic [XLEN-1:0] r_out;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic            r_ovf;
  logic            r_done;

  logic            w_signed;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;
  logic            w_q_bit;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rmd;
  logic [XLEN-1:0] w_result;

  assign w_signed = ~bus.op[0];
  assign w_div0   = (bus.b == '0);
  assign w_ovf    = w_signed && (bus.a == MIN_NEG) && (bus.b == '1);
  assign w_a_abs  = (w_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign w_b_abs  = (w_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;

  // The dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
  assign w_trial  = {r_rem, r_dvd[XLEN-1]};
  assign w_diff   = w_trial - {1'b0, r_dvs};
  assign w_q_bit  = ~w_diff[XLEN];

  assign w_quo    = r_neg_q ? -r_dvd : r_dvd;
  assign w_rmd    = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_result = r_op[1] ? w_rmd : w_quo;
    if (r_div0) begin
      w_result = r_op[1] ? r_a_orig : '1;
    end else if (r_ovf) begin
      w_result = r_op[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef DIV_SEQ_EARLY_OUT_EN
          w_state_nxt = (w_div0 || w_ovf) ? S_FIN : S_CALC;
`else
          w_state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_a_orig <= '0;
      r_out    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.op;
            r_dvd    <= w_a_abs;
            r_dvs    <= w_b_abs;
            r_rem    <= '0;
            r_a_orig <= bus.a;
            r_cnt    <= CW'(XLEN - 1);
            r_neg_q  <= w_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            r_neg_r  <= w_signed & bus.a[XLEN-1];
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
          end
        end
        S_CALC: begin
          r_rem <= w_q_bit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
          r_dvd <= {r_dvd[XLEN-2:0], w_q_bit};
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_FIN: begin
          r_out  <= w_result;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.out     = r_out;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, signed/unsigned results, special cases, reset.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  dbg_state;
  int          n_checks = 0;
  int          n_errors = 0;
  int          overlap = 0;

`ifdef DIV_SEQ_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  div_seq_if #(.XLEN(32)) bus ();

  div_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after an active edge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] res, output int lat, output int bcnt);
    logic seen;
    seen = 1'b0;
    res  = '0;
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done && bus.busy) overlap++;
      if (bus.done) begin
        seen = 1'b1;
        res  = bus.out;
      end else if (bus.busy) begin
        bcnt++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat;
    int          bcnt;
    issue(op, a, b);
    wait_done(res, lat, bcnt);
    check(tag, res, exp);
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          bcnt;
    int          dones;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_out", bus.out, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DIVU 100/7 with latency and busy-width measurement
    issue(2'b01, 32'd100, 32'd7);
    check("calc_state", 32'(dbg_state), 32'd1);
    wait_done(res, lat, bcnt);
    check("divu_100_7", res, 32'd14);
    check("divu_100_7_lat", lat, 33);
    check("divu_100_7_busy", bcnt, 33);

    run("rem_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("div_m7_2",   2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("div_7_m2",   2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run("rem_7_m2",   2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    run("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run("divu_big",   2'b01, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33);
    run("divu_min_m1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
    run("remu_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);

    run("div_by0",     2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
    run("divu_by0",    2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
    run("remu_by0",    2'b11, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
    run("rem_by0_neg", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, SPECIAL_LAT);
    run("div_ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT);
    run("rem_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, SPECIAL_LAT);

    // start while busy is ignored
    issue(2'b01, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(res, lat, bcnt);
    check("ignore_start", res, 32'd14);
    check("ignore_start_lat", lat, 23);

    // back-to-back start in the done cycle
    bus.op    = 2'b01;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done(res, lat, bcnt);
    check("b2b_divu_9_3", res, 32'd3);
    check("b2b_lat", lat, 33);

    // asynchronous reset mid-operation
    issue(2'b01, 32'd100, 32'd7);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_out", bus.out, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dones = 0;
    repeat (40) begin
      if (bus.done) dones++;
      @(posedge clk);
      #1;
    end
    check("no_done_after_rst", dones, 0);
    run("divu_50_5", 2'b01, 32'd50, 32'd5, 32'd10, 33);

    check("done_busy_excl", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle integer divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- It is the inverse-operation companion to the single-cycle multiply datapath in the ALU.
- Radix-2 restoring divider with a start/busy/done handshake.
- Sits beside the ALU in the execute stage. The pipeline stalls while busy is high.

Parameters:
- XLEN, 32, operand and result width in bits; must be ≥ 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation: 00=DIV (signed), 01=DIVU, 10=REM (signed), 11=REMU.
- a  input  XLEN  dividend; sampled with start.
- b  input  XLEN  divisor; sampled with start.
- busy  output  1  high from the edge that accepts start until the done cycle; done and busy are never high together.
- done  output  1  one-cycle pulse; out is valid in that cycle.
- out  output  XLEN  quotient or remainder. Held stable from done until the next accepted start.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation):
  - busy=0, done=0, out=0, state=IDLE; counter, remainder and quotient registers all cleared.
  - Any in-flight operation is discarded.
  - After release, no done pulse occurs until a new start is accepted.
- States: IDLE, CALC, FIN.
- IDLE, with start=1 at an edge:
  - Latch op.
  - For signed ops, latch |a| and |b|, plus sign flags: quotient negate = a[XLEN-1]^b[XLEN-1]; remainder negate = a[XLEN-1].
  - For unsigned ops, latch a and b unchanged.
  - Clear the partial remainder, load counter=XLEN-1, busy←1, go to CALC.
- CALC: one quotient bit per cycle, MSB first.
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor using an XLEN+1-bit subtract.
  - If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - When counter=0, go to FIN; otherwise decrement the counter.
  - CALC lasts exactly XLEN cycles.
- FIN: apply sign correction (two's-complement negate) per the latched flags, register out, done←1, busy←0, go to IDLE. done is high for that cycle only.
- Latency: with start sampled at edge N, done and out are valid after edge N+XLEN+1 (N+33 when XLEN=32). Back-to-back: start may be asserted in the done cycle; it is accepted.
- start while busy=1: ignored; operands are not re-sampled.
- Divide by zero (b=0), result as per the RISC-V spec:
  - DIV/DIVU: out=all ones.
  - REM/REMU: out=a, the original unsigned bit pattern.
  - Detected at start and forced in FIN, regardless of the datapath.
- Signed overflow (a=−2^(XLEN−1), b=−1):
  - DIV: out=−2^(XLEN−1).
  - REM: out=0.
  - Forced in FIN.
- The remainder takes the sign of the dividend; the quotient truncates toward zero.
- No exceptions are raised.

Optional Feature:
- Macro: DIV_SEQ_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow cases skip CALC.
  - IDLE goes directly to FIN on the accepting edge.
  - done is asserted after edge N+1, i.e. 1-cycle latency.
  - Normal cases keep XLEN+1 latency.
- Undefined: every operation takes XLEN+1 cycles. Special-case results are identical either way.

Test Plan:
- DIVU a=100, b=7 → done 33 cycles after start, out=14; busy high for exactly 33 cycles beforehand.
- REM a=−7 (0xFFFFFFF9), b=2 → out=0xFFFFFFFF (−1). DIV with the same operands → out=0xFFFFFFFD (−3).
- DIV a=5, b=0 → out=0xFFFFFFFF; REMU a=5, b=0 → out=5. Latency is 33 cycles without the macro, 1 cycle with DIV_SEQ_EARLY_OUT_EN.
- DIV a=0x80000000, b=0xFFFFFFFF → out=0x80000000; REM with the same operands → out=0.
- Start DIVU 100/7, pulse start again at cycle 10 with a=1, b=1 → second request ignored, out=14. Then start in the done cycle with a=9, b=3 → accepted, out=3 after 33 cycles.
- Assert rst_n=0 at cycle 15 of a DIVU → busy=0, done=0, out=0 immediately (asynchronous). No done pulse after release; a subsequent DIVU 50/5 → out=10.
